net_egress_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter. Merges NUM_MASTERS per-master egress AXIS streams

---
 rtl/net_egress_rr_arbiter_pkg.sv | 31 +++
 rtl/net_egress_rr_arbiter_if.sv | 24 ++
 rtl/net_egress_rr_arbiter_rr_select.sv | 30 +++
 rtl/net_egress_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_net_egress_rr_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/net_egress_rr_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the egress round-robin arbiter.
package net_egress_rr_arbiter_pkg;

    // IDLE: pick the next master; PASS: forward its packet; DROP: sink an over-long tail.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } arb_state_t;

    // Number of bus beats needed to carry a packet of len bytes.
    function automatic int max_beats(input int len, input int bytes);
        return (len + bytes - 1) / bytes;
    endfunction

    // Ceiling log2 that never returns less than 1, so it can size ports directly.
    function automatic int clog2_safe(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Sideband widths below 1 still produce a 1-bit port.
    function automatic int width_or_one(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/net_egress_rr_arbiter_if.sv
// AXI-Stream bundle carrying LANES parallel streams as flat packed vectors.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready are
// both high; a source holds tvalid and its payload stable until that edge, and
// tvalid never waits on tready.
interface net_egress_rr_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int DEST_W = 4,
    parameter int LANES  = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*ID_W-1:0]   tid;
    logic [LANES*DEST_W-1:0] tdest;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES-1:0]        tlast;
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;

    modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/net_egress_rr_arbiter_rr_select.sv
// Combinational round-robin pick: first set req bit above 'last', wrapping at N.
module net_egress_rr_arbiter_rr_select
    import net_egress_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_safe(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] cand;

    // Walk candidates last+1, last+2, ... (mod N) and keep the first requester.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        cand    = last;
        for (int i = 0; i < N; i++) begin
            cand = (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/net_egress_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_MASTERS AXIS streams onto one port.
// A grant lasts from first beat to tlast; packets beyond MAX_BEATS beats are cut
// (tlast forced on the last allowed beat) and their tail is sunk.
module net_egress_rr_arbiter
    import net_egress_rr_arbiter_pkg::*;
#(
    parameter int  AXIS_BUS_WIDTH    = 64,
    parameter int  AXIS_ID_WIDTH     = 4,
    parameter int  AXIS_DEST_WIDTH   = 4,
    parameter int  NUM_MASTERS       = 4,
    parameter int  MAX_PACKET_LENGTH = 1522,
    localparam int GNT_W             = clog2_safe(NUM_MASTERS)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    net_egress_rr_arbiter_if.slave         axis_in_all,
    net_egress_rr_arbiter_if.master        axis_out,
    output logic [GNT_W-1:0]               cur_grant,
    output logic [NUM_MASTERS-1:0]         trunc_pulse,
    output arb_state_t                     dbg_state
);

    localparam int KEEP_W    = AXIS_BUS_WIDTH / 8;
    localparam int ID_W      = width_or_one(AXIS_ID_WIDTH);
    localparam int DEST_W    = width_or_one(AXIS_DEST_WIDTH);
    localparam int MAX_BEATS = max_beats(MAX_PACKET_LENGTH, KEEP_W);
    localparam int CNT_W     = clog2_safe(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] BEAT_LIMIT  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] BEAT_PENULT = CNT_W'(MAX_BEATS - 1);

    arb_state_t              state_q, state_d;
    logic [GNT_W-1:0]        cur_grant_q, cur_grant_d;
    logic [GNT_W-1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [NUM_MASTERS-1:0]  trunc_q, trunc_d;

    logic [GNT_W-1:0]          pick_idx;
    logic                      pick_any;
    logic [NUM_MASTERS-1:0]    gnt_oh;
    logic [NUM_MASTERS-1:0]    in_tready;
    logic                      sel_tvalid;
    logic                      sel_tlast;
    logic [AXIS_BUS_WIDTH-1:0] sel_tdata;
    logic [ID_W-1:0]           sel_tid;
    logic [DEST_W-1:0]         sel_tdest;
    logic [KEEP_W-1:0]         sel_tkeep;
    logic                      out_tvalid;
    logic                      out_tlast;
    logic                      at_limit;

    net_egress_rr_arbiter_rr_select #(
        .N     (NUM_MASTERS),
        .IDX_W (GNT_W)
    ) u_rr_select (
        .req     (axis_in_all.tvalid),
        .last    (last_grant_q),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // Select the granted lane's payload and build its one-hot grant mask.
    always_comb begin
        gnt_oh     = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tdata  = '0;
        sel_tid    = '0;
        sel_tdest  = '0;
        sel_tkeep  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (cur_grant_q == GNT_W'(i)) begin
                gnt_oh[i]  = 1'b1;
                sel_tvalid = axis_in_all.tvalid[i];
                sel_tlast  = axis_in_all.tlast[i];
                sel_tdata  = axis_in_all.tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
                sel_tid    = axis_in_all.tid[i*ID_W +: ID_W];
                sel_tdest  = axis_in_all.tdest[i*DEST_W +: DEST_W];
                sel_tkeep  = axis_in_all.tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    // The beat about to transfer is number MAX_BEATS of the packet.
    assign at_limit = (beat_cnt_q == BEAT_PENULT);

    // Next-state, grant, beat counting and handshake steering.
    always_comb begin
        state_d      = state_q;
        cur_grant_d  = cur_grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        trunc_d      = '0;
        out_tvalid   = 1'b0;
        out_tlast    = sel_tlast;
        in_tready    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    cur_grant_d = pick_idx;
                    state_d     = ST_PASS;
                end
            end
            ST_PASS: begin
                out_tvalid = sel_tvalid;
                in_tready  = axis_out.tready ? gnt_oh : '0;
                if (at_limit) begin
                    out_tlast = 1'b1;
                end
                if (sel_tvalid && axis_out.tready) begin
                    if (sel_tlast) begin
                        state_d      = ST_IDLE;
                        last_grant_d = cur_grant_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = (beat_cnt_q == BEAT_LIMIT) ? beat_cnt_q : beat_cnt_q + 1'b1;
                        if (at_limit) begin
                            trunc_d = gnt_oh;
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                in_tready = gnt_oh;
                if (sel_tvalid && sel_tlast) begin
                    state_d      = ST_IDLE;
                    last_grant_d = cur_grant_q;
                    beat_cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; master 0 wins first.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cur_grant_q  <= '0;
            last_grant_q <= GNT_W'(NUM_MASTERS - 1);
            beat_cnt_q   <= '0;
            trunc_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_grant_q  <= cur_grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            trunc_q      <= trunc_d;
        end
    end

    assign axis_out.tvalid = out_tvalid;
    assign axis_out.tlast  = out_tlast;
    assign axis_out.tdata  = sel_tdata;
    assign axis_out.tid    = sel_tid;
    assign axis_out.tdest  = sel_tdest;
    assign axis_out.tkeep  = sel_tkeep;
    assign axis_in_all.tready = in_tready;

    assign cur_grant   = cur_grant_q;
    assign trunc_pulse = trunc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_net_egress_rr_arbiter.sv
// Randomized bench for net_egress_rr_arbiter with a packet-level reference model.
module tb_net_egress_rr_arbiter;
    import net_egress_rr_arbiter_pkg::*;

    localparam int W      = 64;
    localparam int IDW    = 4;
    localparam int DSW    = 4;
    localparam int N      = 4;
    localparam int MAXLEN = 1522;
    localparam int KW     = W / 8;
    localparam int MAXB   = (MAXLEN + KW - 1) / KW;
    localparam int GW     = 2;
    localparam int EXP_W  = 1 + IDW + DSW + KW + W;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    net_egress_rr_arbiter_if #(.DATA_W(W), .ID_W(IDW), .DEST_W(DSW), .LANES(N)) in_if ();
    net_egress_rr_arbiter_if #(.DATA_W(W), .ID_W(IDW), .DEST_W(DSW), .LANES(1)) out_if ();

    logic [GW-1:0] cur_grant;
    logic [N-1:0]  trunc_pulse;
    arb_state_t    dbg_state;

    net_egress_rr_arbiter #(
        .AXIS_BUS_WIDTH    (W),
        .AXIS_ID_WIDTH     (IDW),
        .AXIS_DEST_WIDTH   (DSW),
        .NUM_MASTERS       (N),
        .MAX_PACKET_LENGTH (MAXLEN)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .axis_in_all (in_if),
        .axis_out    (out_if),
        .cur_grant   (cur_grant),
        .trunc_pulse (trunc_pulse),
        .dbg_state   (dbg_state)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- source state ----------------
    int           pend_len [N][16];
    int           pend_rd  [N];
    int           pend_wr  [N];
    int           seq_no   [N];
    int           beat_idx [N];
    logic [N-1:0] valid_r;
    logic [N-1:0] hs_in;
    int           valid_pct = 100;
    int           ready_pct = 100;

    function automatic logic [W-1:0] beat_data(input int m, input int s, input int b);
        return {8'(m), 24'(s), 32'(b)};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int s, input int b, input int len);
        if (b == len - 1) return KW'((1 << ((s % KW) + 1)) - 1);
        return '1;
    endfunction

    function automatic logic [DSW-1:0] beat_dest(input int s);
        return DSW'(s);
    endfunction

    function automatic int cur_len(input int m);
        return pend_len[m][pend_rd[m] % 16];
    endfunction

    function automatic bit any_pending();
        for (int m = 0; m < N; m++) if (pend_wr[m] != pend_rd[m]) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- reference model ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               grant_log[$];
    int               exp_log[$];
    bit               m_busy   = 1'b0;
    bit               m_drop   = 1'b0;
    int               m_g      = 0;
    int               m_last   = N - 1;
    int               m_beats  = 0;
    logic [N-1:0]     exp_trunc = '0;
    bit               hold_pend = 1'b0;
    int               out_cnt[N];
    int               trunc_cnt = 0;
    int               drop_cnt  = 0;
    logic [N-1:0]     rdy_seen  = '0;
    logic [N-1:0]     exp_rdy;
    logic             exp_vld;
    logic [EXP_W-1:0] got_beat;
    logic [EXP_W-1:0] exp_beat;

    // Next master after 'last' (mod N) that is offering a packet.
    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Queue the wire image of master g's current packet, cut at MAXB beats.
    task automatic push_packet(input int g);
        int len, s, nb;
        len = cur_len(g);
        s   = seq_no[g];
        nb  = (len < MAXB) ? len : MAXB;
        for (int b = 0; b < nb; b++) begin
            exp_q.push_back({((b == len - 1) || (b == MAXB - 1)), IDW'(g), beat_dest(s),
                             beat_keep(s, b, len), beat_data(g, s, b)});
        end
    endtask

    always @(negedge aclk) begin
        hs_in = in_if.tvalid & in_if.tready;
        if (!aresetn) begin
            m_busy    = 1'b0;
            m_drop    = 1'b0;
            m_g       = 0;
            m_last    = N - 1;
            m_beats   = 0;
            exp_trunc = '0;
            hold_pend = 1'b0;
            exp_q.delete();
        end else begin
            rdy_seen = rdy_seen | in_if.tready;
            if (trunc_pulse != '0) trunc_cnt++;
            if (!m_busy) begin
                exp_vld = 1'b0;
                exp_rdy = '0;
            end else if (!m_drop) begin
                exp_vld = in_if.tvalid[m_g];
                exp_rdy = out_if.tready[0] ? (N'(1) << m_g) : '0;
            end else begin
                exp_vld = 1'b0;
                exp_rdy = N'(1) << m_g;
            end
            check("out_tvalid", out_if.tvalid, exp_vld);
            check("in_tready", in_if.tready, exp_rdy);
            check("trunc_pulse", trunc_pulse, exp_trunc);
            if (m_busy) check("cur_grant", cur_grant, m_g);
            if (hold_pend) check("tvalid_hold", out_if.tvalid, 1);
            hold_pend = out_if.tvalid[0] && !out_if.tready[0];
            if (out_if.tvalid[0] && out_if.tready[0]) begin
                got_beat = {out_if.tlast, out_if.tid, out_if.tdest, out_if.tkeep, out_if.tdata};
                check("beat_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check("out_beat", got_beat, exp_beat);
                end
                if (int'(out_if.tid) < N) out_cnt[out_if.tid]++;
            end
            // advance the model by one cycle
            exp_trunc = '0;
            if (!m_busy) begin
                if (in_if.tvalid != '0) begin
                    m_g     = rr_pick(m_last, in_if.tvalid);
                    m_busy  = 1'b1;
                    m_drop  = 1'b0;
                    m_beats = 0;
                    push_packet(m_g);
                    grant_log.push_back(m_g);
                end
            end else if (!m_drop) begin
                if (in_if.tvalid[m_g] && out_if.tready[0]) begin
                    m_beats++;
                    if (in_if.tlast[m_g]) begin
                        m_busy = 1'b0;
                        m_last = m_g;
                    end else if (m_beats == MAXB) begin
                        m_drop         = 1'b1;
                        exp_trunc[m_g] = 1'b1;
                    end
                end
            end else begin
                if (in_if.tvalid[m_g]) begin
                    drop_cnt++;
                    if (in_if.tlast[m_g]) begin
                        m_busy = 1'b0;
                        m_last = m_g;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_lane(input int m);
        int len;
        if (valid_r[m]) begin
            len = cur_len(m);
            in_if.tvalid[m]              = 1'b1;
            in_if.tlast[m]               = (beat_idx[m] == len - 1);
            in_if.tdata[m*W +: W]        = beat_data(m, seq_no[m], beat_idx[m]);
            in_if.tkeep[m*KW +: KW]      = beat_keep(seq_no[m], beat_idx[m], len);
            in_if.tid[m*IDW +: IDW]      = IDW'(m);
            in_if.tdest[m*DSW +: DSW]    = beat_dest(seq_no[m]);
        end else begin
            in_if.tvalid[m]              = 1'b0;
            in_if.tlast[m]               = 1'b0;
            in_if.tdata[m*W +: W]        = '0;
            in_if.tkeep[m*KW +: KW]      = '0;
            in_if.tid[m*IDW +: IDW]      = '0;
            in_if.tdest[m*DSW +: DSW]    = '0;
        end
    endtask

    task automatic load(input int m, input int len);
        pend_len[m][pend_wr[m] % 16] = len;
        pend_wr[m]++;
    endtask

    // One clock: retire handshaken beats, offer new ones, pick a sink ready.
    task automatic step();
        @(posedge aclk);
        #1;
        for (int m = 0; m < N; m++) begin
            if (valid_r[m] && hs_in[m]) begin
                beat_idx[m]++;
                if (beat_idx[m] == cur_len(m)) begin
                    pend_rd[m]++;
                    seq_no[m]++;
                    beat_idx[m] = 0;
                end
                valid_r[m] = 1'b0;
            end
            if (!valid_r[m] && (pend_wr[m] != pend_rd[m]) && ($urandom_range(0, 99) < valid_pct))
                valid_r[m] = 1'b1;
            drive_lane(m);
        end
        out_if.tready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic flush_sources();
        for (int m = 0; m < N; m++) begin
            valid_r[m]  = 1'b0;
            pend_rd[m]  = pend_wr[m];
            beat_idx[m] = 0;
            seq_no[m]++;
            drive_lane(m);
        end
    endtask

    task automatic run_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((any_pending() || m_busy) && k < budget) begin
            step();
            k++;
        end
        check({tag, "_done"}, k < budget, 1);
        repeat (2) step();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_ngrants"}, grant_log.size(), exp_log.size());
        for (int i = 0; i < grant_log.size() && i < exp_log.size(); i++)
            check({tag, "_grant"}, grant_log[i], exp_log[i]);
    endtask

    task automatic clear_stats();
        for (int m = 0; m < N; m++) out_cnt[m] = 0;
        trunc_cnt = 0;
        drop_cnt  = 0;
        rdy_seen  = '0;
        grant_log.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int len;
        for (int m = 0; m < N; m++) begin
            pend_rd[m] = 0; pend_wr[m] = 0; seq_no[m] = 0; beat_idx[m] = 0; out_cnt[m] = 0;
        end
        valid_r = '0;
        hs_in   = '0;
        for (int m = 0; m < N; m++) drive_lane(m);
        out_if.tready = 1'b0;
        aresetn = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;

        // reset state
        @(negedge aclk);
        check("rst_tvalid", out_if.tvalid, 0);
        check("rst_tready", in_if.tready, 0);
        check("rst_trunc", trunc_pulse, 0);
        check("rst_grant", cur_grant, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // 1: one 4-beat packet per master, served 0..3
        clear_stats();
        for (int m = 0; m < N; m++) load(m, 4);
        run_idle("t1", 200);
        exp_log = '{0, 1, 2, 3};
        check_log("t1");

        // 2: masters 1 and 3 alternate, 0 and 2 never see tready
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            load(1, 3);
            load(3, 3);
        end
        run_idle("t2", 200);
        exp_log = '{1, 3, 1, 3, 1, 3};
        check_log("t2");
        check("t2_rdy02", rdy_seen & 4'b0101, 0);

        // 3: sink stalls during a packet from master 2
        clear_stats();
        ready_pct = 50;
        load(2, 20);
        run_idle("t3", 300);
        ready_pct = 100;
        exp_log = '{2};
        check_log("t3");
        check("t3_beats", out_cnt[2], 20);

        // 4: 200-beat packet from master 0 is cut at MAXB beats
        clear_stats();
        load(0, 200);
        repeat (5) step();
        load(1, 4);
        load(3, 4);
        run_idle("t4", 600);
        exp_log = '{0, 1, 3};
        check_log("t4");
        check("t4_beats0", out_cnt[0], 191);
        check("t4_trunc", trunc_cnt, 1);
        check("t4_drop", drop_cnt, 9);

        // 5: exactly MAXB beats is a normal end
        clear_stats();
        load(1, 191);
        run_idle("t5", 600);
        exp_log = '{1};
        check_log("t5");
        check("t5_beats1", out_cnt[1], 191);
        check("t5_trunc", trunc_cnt, 0);
        check("t5_drop", drop_cnt, 0);

        // 6: reset in the middle of master 2's packet
        clear_stats();
        load(2, 10);
        load(3, 2);
        k = 0;
        while (beat_idx[2] != 2 && k < 100) begin
            step();
            k++;
        end
        check("t6_reach", k < 100, 1);
        aresetn = 1'b0;
        step();
        flush_sources();
        aresetn = 1'b1;
        @(negedge aclk);
        check("t6_tready", in_if.tready, 0);
        check("t6_tvalid", out_if.tvalid, 0);
        check("t6_grant", cur_grant, 0);
        clear_stats();
        load(3, 2);
        load(1, 2);
        run_idle("t6", 200);
        exp_log = '{1, 3};
        check_log("t6");

        // random traffic: bubbles, stalls, occasional over-long packets
        clear_stats();
        valid_pct = 70;
        ready_pct = 70;
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < N; m++) begin
                if ((pend_wr[m] - pend_rd[m] < 4) && ($urandom_range(0, 99) < 8)) begin
                    len = ($urandom_range(0, 49) == 0) ? $urandom_range(190, 196) : $urandom_range(1, 12);
                    load(m, len);
                end
            end
            step();
        end
        run_idle("rnd", 20000);
        check("rnd_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
